// File: rtl/ex_alu_rs.sv
// ALU reservation station: buffers decoded ops, wakes operands from the CDB, issues one ready
// op per cycle into the combinational ALU and registers the result toward the CDB arbiter.
module ex_alu_rs #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TYPE_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [TYPE_W-1:0]            in_alu_type,
  input  logic [DATA_W-1:0]            in_src1,
  input  logic [DATA_W-1:0]            in_src2,
  input  logic                         in_src1_rdy,
  input  logic                         in_src2_rdy,
  input  logic [TAG_W-1:0]             in_src1_tag,
  input  logic [TAG_W-1:0]             in_src2_tag,
  input  logic [TAG_W-1:0]             in_dest_tag,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  output logic [TYPE_W-1:0]            alu_type,
  output logic [DATA_W-1:0]            src1,
  output logic [DATA_W-1:0]            src2,
  input  logic [DATA_W-1:0]            alu_result,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [TAG_W-1:0]             out_tag,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              busy;
    logic [TYPE_W-1:0] op;
    logic [TAG_W-1:0]  dest;
    logic              rdy1;
    logic [TAG_W-1:0]  tag1;
    logic [DATA_W-1:0] val1;
    logic              rdy2;
    logic [TAG_W-1:0]  tag2;
    logic [DATA_W-1:0] val2;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  entry_t             new_ent;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               out_valid_q;
  logic [TAG_W-1:0]   out_tag_q;
  logic [DATA_W-1:0]  out_data_q;
  logic [IDX_W-1:0]   free_idx, sel_idx;
  logic               sel_found, accept, issue;

  assign in_ready  = (count_q < CNT_W'(DEPTH)) && rst && !flush;
  assign accept    = in_valid && in_ready;
  assign issue     = sel_found && (!out_valid_q || out_ready);
  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_data  = out_data_q;
  assign count     = count_q;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!ent_q[i].busy) free_idx = IDX_W'(i);
      if (ent_q[i].busy && ent_q[i].rdy1 && ent_q[i].rdy2) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    alu_type = '0;
    src1     = '0;
    src2     = '0;
    if (issue) begin
      alu_type = ent_q[sel_idx].op;
      src1     = ent_q[sel_idx].val1;
      src2     = ent_q[sel_idx].val2;
    end
  end

  // Incoming op, with same-cycle CDB bypass so a coincident broadcast is not missed.
  always_comb begin
    new_ent      = '0;
    new_ent.busy = 1'b1;
    new_ent.op   = in_alu_type;
    new_ent.dest = in_dest_tag;
    new_ent.rdy1 = in_src1_rdy;
    new_ent.tag1 = in_src1_tag;
    new_ent.val1 = in_src1;
    new_ent.rdy2 = in_src2_rdy;
    new_ent.tag2 = in_src2_tag;
    new_ent.val2 = in_src2;
    if (cdb_valid && !in_src1_rdy && (in_src1_tag == cdb_tag)) begin
      new_ent.rdy1 = 1'b1;
      new_ent.val1 = cdb_data;
    end
    if (cdb_valid && !in_src2_rdy && (in_src2_tag == cdb_tag)) begin
      new_ent.rdy2 = 1'b1;
      new_ent.val2 = cdb_data;
    end
  end

  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (cdb_valid && ent_q[i].busy && !ent_q[i].rdy1 && (ent_q[i].tag1 == cdb_tag)) begin
        ent_d[i].rdy1 = 1'b1;
        ent_d[i].val1 = cdb_data;
      end
      if (cdb_valid && ent_q[i].busy && !ent_q[i].rdy2 && (ent_q[i].tag2 == cdb_tag)) begin
        ent_d[i].rdy2 = 1'b1;
        ent_d[i].val2 = cdb_data;
      end
    end
    // Issue and accept never target the same slot: one is busy, the other free.
    if (issue)  ent_d[sel_idx].busy = 1'b0;
    if (accept) ent_d[free_idx] = new_ent;
    if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_d[i].busy = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush)                count_d = '0;
    else if (accept && !issue) count_d = count_q + CNT_W'(1);
    else if (issue && !accept) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (issue) begin
        out_valid_q <= 1'b1;
        out_tag_q   <= ent_q[sel_idx].dest;
        out_data_q  <= alu_result;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_rs.sv
// Self-checking bench for ex_alu_rs: scoreboard of {tag,data} results checked at each handshake.
module tb_ex_alu_rs;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TYPE_W = 5;

  localparam logic [TYPE_W-1:0] OpAdd = 5'd1;
  localparam logic [TYPE_W-1:0] OpSub = 5'd2;
  localparam logic [TYPE_W-1:0] OpXor = 5'd3;
  localparam logic [TYPE_W-1:0] OpAnd = 5'd4;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready;
  logic [TYPE_W-1:0] in_alu_type, alu_type;
  logic [DATA_W-1:0] in_src1, in_src2, src1, src2, alu_result, out_data, cdb_data;
  logic              in_src1_rdy, in_src2_rdy, cdb_valid, out_valid, out_ready;
  logic [TAG_W-1:0]  in_src1_tag, in_src2_tag, in_dest_tag, cdb_tag, out_tag;
  logic [2:0]        count;

  int errors = 0;
  int checks = 0;
  logic [TAG_W+DATA_W-1:0] sb[$];

  ex_alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .TYPE_W(TYPE_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_type(in_alu_type),
    .in_src1(in_src1), .in_src2(in_src2), .in_src1_rdy(in_src1_rdy), .in_src2_rdy(in_src2_rdy),
    .in_src1_tag(in_src1_tag), .in_src2_tag(in_src2_tag), .in_dest_tag(in_dest_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_type(alu_type), .src1(src1), .src2(src2), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  // Stand-in for the execute-stage ALU.
  always_comb begin
    alu_result = '0;
    case (alu_type)
      OpAdd:   alu_result = src1 + src2;
      OpSub:   alu_result = src1 - src2;
      OpXor:   alu_result = src1 ^ src2;
      OpAnd:   alu_result = src1 & src2;
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {32'd0, out_data}, 64'hffff_ffff_ffff_ffff);
      end else begin
        logic [TAG_W+DATA_W-1:0] e;
        e = sb.pop_front();
        chk("out_tag", 64'(out_tag), 64'(e[TAG_W+DATA_W-1:DATA_W]));
        chk("out_data", 64'(out_data), 64'(e[DATA_W-1:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    sb.push_back({t, d});
  endtask

  task automatic drive_op(input logic [TYPE_W-1:0] op, input logic [DATA_W-1:0] a,
                          input logic ar, input logic [TAG_W-1:0] at,
                          input logic [DATA_W-1:0] b, input logic br,
                          input logic [TAG_W-1:0] bt, input logic [TAG_W-1:0] dest);
    in_valid    = 1'b1;
    in_alu_type = op;
    in_src1     = a;
    in_src1_rdy = ar;
    in_src1_tag = at;
    in_src2     = b;
    in_src2_rdy = br;
    in_src2_tag = bt;
    in_dest_tag = dest;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_alu_type = '0; in_src1 = '0; in_src2 = '0; in_src1_rdy = 1'b0; in_src2_rdy = 1'b0;
    in_src1_tag = '0; in_src2_tag = '0; in_dest_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;

    // Reset / idle
    repeat (2) tick();
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("idle_out_valid", 64'(out_valid), 0);
    chk("idle_count", 64'(count), 0);
    chk("idle_in_ready", 64'(in_ready), 1);
    chk("idle_alu_type", 64'(alu_type), 0);
    tick();

    // Ready op: 5 + 7 -> tag 3
    out_ready = 1'b1;
    drive_op(OpAdd, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 4'd3);
    push(4'd3, 32'd12);
    @(negedge clk);
    chk("add_in_ready", 64'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("add_count1", 64'(count), 1);
    chk("add_issue_type", 64'(alu_type), 64'(OpAdd));
    chk("add_issue_src1", 64'(src1), 5);
    chk("add_issue_src2", 64'(src2), 7);
    chk("add_no_out_yet", 64'(out_valid), 0);
    tick();
    @(negedge clk);
    chk("add_out_valid", 64'(out_valid), 1);
    chk("add_count0", 64'(count), 0);
    tick();
    @(negedge clk);
    chk("add_out_clear", 64'(out_valid), 0);
    tick();

    // Wakeup: src1 waits on tag 9; a broadcast of tag 8 must not wake it
    drive_op(OpAdd, 32'd0, 1'b0, 4'd9, 32'd1, 1'b1, 4'd0, 4'd5);
    @(negedge clk);
    chk("wk_in_ready", 64'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd8; cdb_data = 32'hdead;
    tick();
    cdb_valid = 1'b0;
    @(negedge clk);
    chk("wk_wrong_tag_idle", 64'(alu_type), 0);
    chk("wk_count", 64'(count), 1);
    tick();
    @(negedge clk);
    chk("wk_no_issue", 64'(out_valid), 0);
    push(4'd5, 32'h11);
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'h10;
    tick();
    cdb_valid = 1'b0;
    @(negedge clk);
    chk("wk_edge1_out", 64'(out_valid), 0);
    chk("wk_issue_src1", 64'(src1), 32'h10);
    tick();
    @(negedge clk);
    chk("wk_edge2_out", 64'(out_valid), 1);
    tick();

    // Bypass: broadcast in the same cycle as the accept
    drive_op(OpAdd, 32'd0, 1'b0, 4'd9, 32'd1, 1'b1, 4'd0, 4'd6);
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'h10;
    push(4'd6, 32'h11);
    @(negedge clk);
    chk("byp_in_ready", 64'(in_ready), 1);
    tick();
    in_valid = 1'b0; cdb_valid = 1'b0;
    @(negedge clk);
    chk("byp_issue_src1", 64'(src1), 32'h10);
    tick();
    @(negedge clk);
    chk("byp_out_valid", 64'(out_valid), 1);
    tick();

    // Full / backpressure: park one result in the output register, then fill all entries
    out_ready = 1'b0;
    drive_op(OpXor, 32'hff00, 1'b1, 4'd0, 32'h0ff0, 1'b1, 4'd0, 4'd1);
    push(4'd1, 32'hf0f0);
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("bp_parked", 64'(out_valid), 1);
    chk("bp_count0", 64'(count), 0);
    tick();
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive_op(OpSub, 32'(100 + i), 1'b1, 4'd0, 32'(i), 1'b1, 4'd0, 4'(10 + i));
      push(4'(10 + i), 32'd100);
      @(negedge clk);
      chk("bp_fill_ready", 64'(in_ready), 1);
      tick();
    end
    drive_op(OpAdd, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd14);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 0);
    chk("full_count", 64'(count), 4);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_hold_count", 64'(count), 4);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i <= int'(DEPTH); i++) begin
      @(negedge clk);
      chk("drain_back_to_back", 64'(out_valid), 1);
      tick();
    end
    @(negedge clk);
    chk("drain_done", 64'(out_valid), 0);
    chk("drain_count", 64'(count), 0);
    tick();

    // Flush with three busy entries and a parked result
    out_ready = 1'b0;
    drive_op(OpAdd, 32'd2, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 4'd2);
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_op(OpAdd, 32'(i), 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'(3 + i));
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_pre_count", 64'(count), 3);
    chk("fl_pre_out", 64'(out_valid), 1);
    tick();
    flush = 1'b1;
    drive_op(OpAdd, 32'd9, 1'b1, 4'd0, 32'd9, 1'b1, 4'd0, 4'd7);
    @(negedge clk);
    chk("fl_in_ready", 64'(in_ready), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fl_count", 64'(count), 0);
    chk("fl_out_valid", 64'(out_valid), 0);
    tick();
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("fl_nothing_out", 64'(out_valid), 0);
      tick();
    end

    // Simultaneous: full station, one ready entry, out_ready rises while in_valid is held
    out_ready = 1'b0;
    drive_op(OpAdd, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 4'd8);
    push(4'd8, 32'd3);
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_op(OpAdd, 32'd0, 1'b0, 4'd2, 32'(10 * (i + 1)), 1'b1, 4'd0, 4'(9 + i));
      tick();
    end
    drive_op(OpAnd, 32'hf0f0, 1'b1, 4'd0, 32'h0ff0, 1'b1, 4'd0, 4'd12);
    push(4'd12, 32'h00f0);
    tick();
    out_ready = 1'b1;
    drive_op(OpSub, 32'd50, 1'b1, 4'd0, 32'd8, 1'b1, 4'd0, 4'd13);
    push(4'd13, 32'd42);
    @(negedge clk);
    chk("sim_in_ready0", 64'(in_ready), 0);
    chk("sim_count4", 64'(count), 4);
    chk("sim_issue_type", 64'(alu_type), 64'(OpAnd));
    chk("sim_issue_src1", 64'(src1), 32'hf0f0);
    tick();
    @(negedge clk);
    chk("sim_in_ready1", 64'(in_ready), 1);
    chk("sim_count3", 64'(count), 3);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("sim_accepted", 64'(count), 4);
    tick();
    tick();
    push(4'd9, 32'd110);
    push(4'd10, 32'd120);
    push(4'd11, 32'd130);
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'd100;
    tick();
    cdb_valid = 1'b0;

    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    chk("scoreboard_empty", 64'(sb.size()), 0);
    repeat (2) tick();
    @(negedge clk);
    chk("final_count", 64'(count), 0);
    chk("final_out_valid", 64'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_alu_rs.md
# ex_alu_rs

Reservation station feeding the combinational execute-stage ALU. It buffers up to DEPTH decoded ALU operations and wakes waiting operands by snooping the common data bus (CDB). It selects one ready entry per cycle, drives its opcode and operands into the ALU, and registers the ALU result with its destination tag toward the CDB arbiter. It sits between dispatch and the ALU as the operand-producing end of the ALU interface.

## Interface
- DEPTH, 4, number of station entries (2..8)
- TAG_W, 4, ROB tag width
- DATA_W, 32, operand/result width
- TYPE_W, 5, ALU opcode width; matches the ALU's opcode field
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low (state clears on a rising clk edge while rst==0)
- flush  in  1  synchronous kill of all entries and the output register
- in_valid  in  1  dispatch offers an op
- in_ready  out  1  station can accept an op this cycle
- in_alu_type  in  TYPE_W  opcode
- in_src1 / in_src2  in  DATA_W  operand value, meaningful when its rdy bit is 1
- in_src1_rdy / in_src2_rdy  in  1  operand value already valid
- in_src1_tag / in_src2_tag  in  TAG_W  producer tag when not ready
- in_dest_tag  in  TAG_W  tag of this op's result
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_data  in  DATA_W  broadcast value
- alu_type  out  TYPE_W  opcode to ALU
- src1 / src2  out  DATA_W  operands to ALU
- alu_result  in  DATA_W  combinational ALU result for alu_type/src1/src2
- out_valid  out  1  registered result pending
- out_ready  in  1  CDB arbiter takes the result
- out_tag  out  TAG_W  destination tag of the result
- out_data  out  DATA_W  result value
- count  out  $clog2(DEPTH+1)  number of occupied entries

## Operation
- Entry fields: busy, type, dest_tag, and per operand {rdy, tag, value}.
- Accept on in_valid && in_ready. The op writes the lowest-index free entry.
- in_ready = (count < DEPTH) && rst && !flush. A slot freed in the same cycle is not counted.
- Wakeup: on cdb_valid, every busy entry operand with rdy==0 and tag==cdb_tag captures cdb_data and sets rdy=1.
- Bypass at accept: an incoming operand with rdy==0 and tag==cdb_tag on a valid CDB is written with cdb_data and rdy=1.
- Select: the lowest-index busy entry with both rdy==1 is chosen. Issue happens when one exists and (!out_valid || out_ready).
- On issue:
  - alu_type/src1/src2 show the chosen entry combinationally.
  - At the edge, out_data<=alu_result and out_tag<=dest_tag.
  - out_valid<=1 and the entry is freed.
- No issue: alu_type/src1/src2 drive 0. out_valid is cleared on out_ready, otherwise held with out_tag/out_data stable.
- Flush: all busy<=0, out_valid<=0, count<=0. Flush overrides same-cycle accept and issue.
- count = number of busy entries after each edge. Accept and issue in the same cycle leave it unchanged.
- Reset (rst==0 at an edge): all busy=0, out_valid=0, out_tag=0, out_data=0, count=0. While rst==0, in_ready=0. Reset in the middle of an operation drops all state with no partial output.

## Timing
- Accept with both operands ready at edge E0 gives issue in cycle E0→E1 and out_valid=1 after E1. Minimum latency is one cycle.
- CDB wakeup at edge E makes the entry eligible in the cycle following E.
- Backpressure: while out_valid && !out_ready, nothing issues and entries stay. Issue resumes in the same cycle out_ready is seen high.
- One issue and one accept per cycle at most. Full throughput is one result per cycle when out_ready stays high.
- An op accepted in the same cycle as a matching CDB broadcast never misses that broadcast.

## Test plan
- Reset/idle: hold rst=0 for 2 cycles, then release. Required: out_valid=0, count=0, in_ready=1 after release, alu_type=0.
- Ready op: accept ADD with src1=5, src2=7, dest_tag=3, out_ready=1. Required: out_valid=1 one cycle later with out_tag=3 and out_data=12, and count returns to 0.
- Wakeup and bypass:
  - Accept an op with src1 waiting on tag 9. Required: no issue.
  - Broadcast cdb_tag=9, cdb_data=0x10. Required: result appears two edges after the broadcast.
  - Repeat with the broadcast in the same cycle as the accept. Required: the captured value is identical.
- Full/backpressure: hold out_ready=0 and fill DEPTH=4 ready ops, then a fifth. Required: in_ready=0 and count=4. Release out_ready. Required: results come out in entry order 0,1,2,3, one per cycle.
- Flush: with 3 busy entries and out_valid=1, pulse flush together with in_valid. Required: count=0 and out_valid=0 next cycle, and the offered op is dropped.
- Simultaneous events: with the station full, one ready entry, and out_ready=1, in_valid is held. Required: in_ready=0 this cycle, issue proceeds, and accept succeeds the next cycle.
